// File: rtl/mc_control_if.sv
// Control bus between the multicycle MIPS control FSM (master) and the datapath (slave).
// The master reads the opcode and memory handshake and drives every enable and mux select.
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic             mem_ready;
    logic             IorD;
    logic             IRwrite;
    logic             memwrite;
    logic             memtoreg;
    logic             pcwrite;
    logic             regwrite;
    logic             regdst;
    logic             alusrcA;
    logic             branch;
    logic             branch_ne;
    logic [1:0]       alusrcB;
    logic [1:0]       pcsrc;
    logic [2:0]       aluop;
    logic             illegal;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state;

    modport master (
        input  op, mem_ready,
        output IorD, IRwrite, memwrite, memtoreg, pcwrite, regwrite, regdst, alusrcA,
               branch, branch_ne, alusrcB, pcsrc, aluop, illegal, retire, instret, state
    );

    modport slave (
        output op, mem_ready,
        input  IorD, IRwrite, memwrite, memtoreg, pcwrite, regwrite, regdst, alusrcA,
               branch, branch_ne, alusrcB, pcsrc, aluop, illegal, retire, instret, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: Moore FSM with memory wait states, optional BNE and
// immediate-logic opcodes, illegal-opcode trap and a retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction, PC += 4 (waits for memory)
// DECODE | register read, branch target into ALUOut
// MEMADR | compute load/store address
// MEMRD  | load data read (waits for memory)
// MEMWB  | load data to register file
// MEMWR  | store data write (waits for memory)
// REXEC  | R-type ALU operation
// ALUWB  | R-type result to rd
// BEQ    | branch if equal
// BNE    | branch if not equal
// IEXEC  | immediate ALU operation
// IWB    | immediate result to rt
// JUMP   | jump target to PC
// TRAP   | illegal opcode, frozen until reset
module mc_control_fsm #(
    parameter bit WAIT_MEM         = 1'b1,
    parameter bit ENABLE_BNE       = 1'b1,
    parameter bit ENABLE_IMM_LOGIC = 1'b1,
    parameter int CNT_W            = 32
) (
    input logic          clk,
    input logic          reset,
    mc_control_if.master bus
);
    localparam logic [3:0] S_FETCH  = 4'b0000;
    localparam logic [3:0] S_DECODE = 4'b0001;
    localparam logic [3:0] S_MEMADR = 4'b0010;
    localparam logic [3:0] S_MEMRD  = 4'b0011;
    localparam logic [3:0] S_MEMWB  = 4'b0100;
    localparam logic [3:0] S_MEMWR  = 4'b0101;
    localparam logic [3:0] S_REXEC  = 4'b0110;
    localparam logic [3:0] S_ALUWB  = 4'b0111;
    localparam logic [3:0] S_BEQ    = 4'b1000;
    localparam logic [3:0] S_IEXEC  = 4'b1001;
    localparam logic [3:0] S_IWB    = 4'b1010;
    localparam logic [3:0] S_JUMP   = 4'b1011;
    localparam logic [3:0] S_BNE    = 4'b1100;
    localparam logic [3:0] S_TRAP   = 4'b1101;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [3:0]       dec_state;
    logic             ready;
    logic             retire;

    assign ready = WAIT_MEM ? bus.mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_R:                      state_d = S_REXEC;
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_BEQ:                    state_d = S_BEQ;
                    OP_BNE:                    state_d = ENABLE_BNE ? S_BNE : S_TRAP;
                    OP_ADDI:                   state_d = S_IEXEC;
                    OP_ANDI, OP_ORI, OP_SLTI:  state_d = ENABLE_IMM_LOGIC ? S_IEXEC : S_TRAP;
                    OP_J:                      state_d = S_JUMP;
                    default:                   state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (ready) state_d = S_FETCH;
            S_REXEC:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_BNE:    state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        if (!reset) state_d = S_FETCH;
    end

    // While reset is held the outputs show the FETCH decode with all write enables off.
    assign dec_state = reset ? state_q : S_FETCH;

    always_comb begin
        bus.IorD      = 1'b0;
        bus.IRwrite   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.memtoreg  = 1'b0;
        bus.pcwrite   = 1'b0;
        bus.regwrite  = 1'b0;
        bus.regdst    = 1'b0;
        bus.alusrcA   = 1'b0;
        bus.branch    = 1'b0;
        bus.branch_ne = 1'b0;
        bus.alusrcB   = 2'b00;
        bus.pcsrc     = 2'b00;
        bus.aluop     = 3'b000;
        bus.illegal   = 1'b0;
        retire        = 1'b0;
        case (dec_state)
            S_FETCH: begin
                bus.alusrcB = 2'b01;
                bus.IRwrite = ready;
                bus.pcwrite = ready;
            end
            S_DECODE: bus.alusrcB = 2'b11;
            S_MEMADR: begin
                bus.alusrcA = 1'b1;
                bus.alusrcB = 2'b10;
            end
            S_MEMRD: bus.IorD = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                retire       = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.memwrite = 1'b1;
                retire       = ready;
            end
            S_REXEC: begin
                bus.alusrcA = 1'b1;
                bus.aluop   = 3'b010;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                retire       = 1'b1;
            end
            S_BEQ, S_BNE: begin
                bus.alusrcA   = 1'b1;
                bus.aluop     = 3'b001;
                bus.pcsrc     = 2'b01;
                bus.branch    = (dec_state == S_BEQ);
                bus.branch_ne = (dec_state == S_BNE);
                retire        = 1'b1;
            end
            S_IEXEC: begin
                bus.alusrcA = 1'b1;
                bus.alusrcB = 2'b10;
                case (bus.op)
                    OP_ANDI: bus.aluop = 3'b011;
                    OP_ORI:  bus.aluop = 3'b100;
                    OP_SLTI: bus.aluop = 3'b101;
                    default: bus.aluop = 3'b000;
                endcase
            end
            S_IWB: begin
                bus.regwrite = 1'b1;
                retire       = 1'b1;
            end
            S_JUMP: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
                retire      = 1'b1;
            end
            S_TRAP:  bus.illegal = 1'b1;
            default: ;
        endcase
        if (!reset) begin
            bus.IRwrite  = 1'b0;
            bus.pcwrite  = 1'b0;
            bus.memwrite = 1'b0;
            bus.regwrite = 1'b0;
            retire       = 1'b0;
        end
    end

    always_comb begin
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
        if (!reset) instret_d = '0;
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        instret_q <= instret_d;
    end

    assign bus.retire  = retire;
    assign bus.instret = instret_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction step model for the fully enabled unit plus
// directed literal checks on the disabled-option and narrow-counter variants.
module tb_mc_control_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] op_tb;
    logic       mr_tb;
    logic [2:0] rb;

    mc_control_if #(.CNT_W(32)) if0 ();
    mc_control_if #(.CNT_W(32)) if1 ();
    mc_control_if #(.CNT_W(4))  if2 ();

    assign if0.op = op_tb;  assign if0.mem_ready = mr_tb;
    assign if1.op = op_tb;  assign if1.mem_ready = mr_tb;
    assign if2.op = op_tb;  assign if2.mem_ready = mr_tb;

    mc_control_fsm #(.WAIT_MEM(1'b1), .ENABLE_BNE(1'b1), .ENABLE_IMM_LOGIC(1'b1), .CNT_W(32))
        u0 (.clk(clk), .reset(rb[0]), .bus(if0.master));
    mc_control_fsm #(.WAIT_MEM(1'b0), .ENABLE_BNE(1'b0), .ENABLE_IMM_LOGIC(1'b0), .CNT_W(32))
        u1 (.clk(clk), .reset(rb[1]), .bus(if1.master));
    mc_control_fsm #(.WAIT_MEM(1'b1), .ENABLE_BNE(1'b1), .ENABLE_IMM_LOGIC(1'b1), .CNT_W(4))
        u2 (.clk(clk), .reset(rb[2]), .bus(if2.master));

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100,
                           ORI = 6'b001101, SLTI = 6'b001010, J = 6'b000010, BAD = 6'b111111;

    // Phase labels carry the documented state encodings.
    localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMWB = 4, PMW = 5, PRX = 6, PAWB = 7,
                   PBEQ = 8, PIX = 9, PIWB = 10, PJ = 11, PBNE = 12, PTRAP = 13;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Step k of the instruction named by op (k=0 fetch, k=1 decode).
    function automatic int path_phase(input logic [5:0] o, input int k);
        if (k == 0) return PF;
        if (k == 1) return PD;
        case (o)
            LW:                    return (k == 2) ? PMA : (k == 3) ? PMR : PMWB;
            SW:                    return (k == 2) ? PMA : PMW;
            R:                     return (k == 2) ? PRX : PAWB;
            BEQ:                   return PBEQ;
            BNE:                   return PBNE;
            ADDI, ANDI, ORI, SLTI: return (k == 2) ? PIX : PIWB;
            J:                     return PJ;
            default:               return PTRAP;
        endcase
    endfunction

    function automatic int path_len(input logic [5:0] o);
        case (o)
            LW:                        return 5;
            SW, R, ADDI, ANDI, ORI, SLTI: return 4;
            default:                   return 3;
        endcase
    endfunction

    function automatic logic [22:0] exp_vec(input int ph, input logic [5:0] o,
                                            input logic mr, input logic rstb);
        logic iord, irw, mw, mtr, pcw, rw, rd, asa, br, bne, ill, ret;
        logic [1:0] asb, pcs;
        logic [2:0] aop;
        int dp;
        {iord, irw, mw, mtr, pcw, rw, rd, asa, br, bne, ill, ret} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 3'b000;
        dp = rstb ? ph : PF;
        case (dp)
            PF:   begin asb = 2'b01; irw = mr; pcw = mr; end
            PD:   asb = 2'b11;
            PMA:  begin asa = 1; asb = 2'b10; end
            PMR:  iord = 1;
            PMWB: begin mtr = 1; rw = 1; ret = 1; end
            PMW:  begin iord = 1; mw = 1; ret = mr; end
            PRX:  begin asa = 1; aop = 3'b010; end
            PAWB: begin rd = 1; rw = 1; ret = 1; end
            PBEQ: begin asa = 1; aop = 3'b001; pcs = 2'b01; br = 1; ret = 1; end
            PBNE: begin asa = 1; aop = 3'b001; pcs = 2'b01; bne = 1; ret = 1; end
            PIX:  begin
                asa = 1; asb = 2'b10;
                aop = (o == ANDI) ? 3'b011 : (o == ORI) ? 3'b100 : (o == SLTI) ? 3'b101 : 3'b000;
            end
            PIWB: begin rw = 1; ret = 1; end
            PJ:   begin pcs = 2'b10; pcw = 1; ret = 1; end
            PTRAP: ill = 1;
            default: ;
        endcase
        if (!rstb) begin irw = 0; pcw = 0; mw = 0; rw = 0; ret = 0; end
        return {iord, irw, mw, mtr, pcw, rw, rd, asa, br, bne, asb, pcs, aop, ill, ret, 4'(ph)};
    endfunction

    int          m_k = 0;
    bit          m_trap = 0;
    logic [31:0] m_instret = 0;

    always @(posedge clk) begin
        int ph;
        ph = m_trap ? PTRAP : path_phase(op_tb, m_k);
        if (!rb[0]) begin
            m_k = 0; m_trap = 0; m_instret = 0;
        end else if (ph == PTRAP) begin
            m_trap = 1;
        end else if ((ph == PF || ph == PMR || ph == PMW) && !mr_tb) begin
            m_k = m_k;
        end else if (m_k == path_len(op_tb) - 1) begin
            m_k = 0; m_instret = m_instret + 1;
        end else begin
            m_k = m_k + 1;
        end
    end

    always @(negedge clk) begin
        int ph;
        logic [22:0] act;
        ph = m_trap ? PTRAP : path_phase(op_tb, m_k);
        act = {if0.IorD, if0.IRwrite, if0.memwrite, if0.memtoreg, if0.pcwrite, if0.regwrite,
               if0.regdst, if0.alusrcA, if0.branch, if0.branch_ne, if0.alusrcB, if0.pcsrc,
               if0.aluop, if0.illegal, if0.retire, if0.state};
        chk("u0_outputs", 32'(act), 32'(exp_vec(ph, op_tb, mr_tb, rb[0])));
        chk("u0_instret", if0.instret, m_instret);
    end

    task automatic tick(input logic [5:0] o, input logic m, input logic [2:0] r);
        @(posedge clk);
        #1;
        op_tb = o; mr_tb = m; rb = r;
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [2:0] r);
        for (int i = 0; i < path_len(o); i++) tick(o, 1'b1, r);
    endtask

    initial begin
        int mwc, rtc, en_or;
        logic [1:0] sw_mr [6];
        logic [5:0] mix [5];
        op_tb = R; mr_tb = 1'b1; rb = 3'b000;

        tick(R, 1, 3'b000);
        tick(R, 1, 3'b000);
        chk("rst_state", 32'(if0.state), 0);
        chk("rst_instret", if0.instret, 0);
        chk("rst_pcwrite", 32'(if0.pcwrite), 0);

        for (int k = 0; k < 5; k++) begin
            tick(LW, 1, 3'b001);
            chk("lw_state", 32'(if0.state), 32'(k));
            chk("lw_regwrite", 32'(if0.regwrite), (k == 4) ? 1 : 0);
        end
        tick(SW, 1, 3'b001);
        chk("lw_instret", if0.instret, 1);
        chk("lw_back_fetch", 32'(if0.state), 0);

        mwc = 0; rtc = 0;
        sw_mr = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
        for (int i = 0; i < 6; i++) begin
            tick(SW, sw_mr[i][0], 3'b001);
            mwc += int'(if0.memwrite);
            rtc += int'(if0.retire);
        end
        chk("sw_memwrite_cycles", 32'(mwc), 4);
        chk("sw_retires", 32'(rtc), 1);

        tick(R, 0, 3'b001);
        chk("sw_done_fetch", 32'(if0.state), 0);
        chk("fetch_wait_irwrite", 32'(if0.IRwrite), 0);
        tick(R, 0, 3'b001);
        chk("fetch_wait_pcwrite", 32'(if0.pcwrite), 0);
        tick(R, 1, 3'b001);
        chk("fetch_go_irwrite", 32'(if0.IRwrite), 1);
        tick(R, 1, 3'b001);
        chk("fetch_to_decode", 32'(if0.state), 1);
        tick(R, 1, 3'b001);
        tick(R, 1, 3'b001);

        tick(BNE, 1, 3'b001); tick(BNE, 1, 3'b001); tick(BNE, 1, 3'b001);
        chk("bne_branch_ne", 32'(if0.branch_ne), 1);
        chk("bne_aluop", 32'(if0.aluop), 1);
        tick(ORI, 1, 3'b001); tick(ORI, 1, 3'b001); tick(ORI, 1, 3'b001);
        chk("ori_aluop", 32'(if0.aluop), 4);
        tick(ORI, 1, 3'b001);

        mix = '{BEQ, ADDI, ANDI, SLTI, J};
        foreach (mix[i]) run_instr(mix[i], 3'b001);
        tick(LW, 1, 3'b001); tick(LW, 1, 3'b001); tick(LW, 1, 3'b001);
        tick(LW, 0, 3'b001);
        chk("lw_memrd_wait", 32'(if0.state), 3);
        tick(LW, 1, 3'b001); tick(LW, 1, 3'b001);

        tick(BAD, 1, 3'b001); tick(BAD, 1, 3'b001);
        en_or = 0;
        for (int i = 0; i < 10; i++) begin
            tick(BAD, 1, 3'b001);
            chk("trap_illegal", 32'(if0.illegal), 1);
            en_or |= int'({if0.pcwrite, if0.IRwrite, if0.memwrite, if0.regwrite, if0.retire});
        end
        chk("trap_no_enables", 32'(en_or), 0);
        chk("trap_instret_frozen", if0.instret, 11);
        tick(BAD, 1, 3'b000);
        chk("trap_reset_illegal", 32'(if0.illegal), 0);
        tick(R, 1, 3'b001);
        chk("trap_reset_state", 32'(if0.state), 0);
        chk("trap_reset_instret", if0.instret, 0);

        tick(BNE, 1, 3'b010); tick(BNE, 1, 3'b010); tick(BNE, 1, 3'b010);
        chk("u1_bne_trap", 32'(if1.state), 13);
        chk("u1_bne_illegal", 32'(if1.illegal), 1);
        tick(ORI, 1, 3'b000);
        tick(ORI, 1, 3'b010); tick(ORI, 1, 3'b010); tick(ORI, 1, 3'b010);
        chk("u1_ori_trap", 32'(if1.state), 13);
        tick(LW, 0, 3'b000);
        for (int k = 0; k < 5; k++) begin
            tick(LW, 0, 3'b010);
            chk("u1_nowait_state", 32'(if1.state), 32'(k));
            if (k == 0) chk("u1_nowait_irwrite", 32'(if1.IRwrite), 1);
        end
        tick(J, 0, 3'b010);
        chk("u1_nowait_instret", if1.instret, 1);

        for (int i = 0; i < 16; i++) begin
            tick(J, 1, 3'b100);
            if (i == 15) chk("u2_instret_15", 32'(if2.instret), 15);
            tick(J, 1, 3'b100);
            tick(J, 1, 3'b100);
        end
        tick(J, 1, 3'b100);
        chk("u2_instret_wrap", 32'(if2.instret), 0);
        tick(J, 1, 3'b100); tick(J, 1, 3'b100);
        tick(R, 1, 3'b100);
        chk("u2_instret_1", 32'(if2.instret), 1);
        tick(R, 1, 3'b100);
        tick(R, 1, 3'b100);
        chk("u2_rexec", 32'(if2.state), 6);
        tick(R, 1, 3'b000);
        chk("u2_reset_no_retire", 32'(if2.retire), 0);
        chk("u2_reset_regwrite", 32'(if2.regwrite), 0);
        tick(R, 1, 3'b100);
        chk("u2_reset_state", 32'(if2.state), 0);
        chk("u2_reset_instret", 32'(if2.instret), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multicycle MIPS control unit: a Moore FSM that sequences fetch/decode/execute/memory/writeback and drives every datapath enable and mux select. It sits between the instruction register's opcode field and the multicycle datapath. It extends the base decoder with memory wait states, optional BNE and immediate-logic opcodes, an illegal-opcode trap, and a retired-instruction counter.

## Interface
- WAIT_MEM, 1, 1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored (treated as 1)
- ENABLE_BNE, 1, decode BNE (000101); 0: opcode is illegal
- ENABLE_IMM_LOGIC, 1, decode ANDI (001100), ORI (001101), SLTI (001010); 0: illegal
- CNT_W, 32, width of instret counter

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-low
- op  in  6  opcode from instruction register
- mem_ready  in  1  memory completes current access this cycle
- IorD, IRwrite, memwrite, memtoreg, pcwrite, regwrite, regdst, alusrcA  out  1 each  datapath controls
- branch  out  1  PC loads if ALU zero=1
- branch_ne  out  1  PC loads if ALU zero=0
- alusrcB  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- aluop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- illegal  out  1  FSM is in TRAP
- retire  out  1  one-cycle pulse on final cycle of an instruction
- instret  out  CNT_W  retired-instruction count
- state  out  4  current state encoding (debug)

## Operation
- Moore outputs decoded from state only, except mem_ready gating below; every output defaults to 0 in each state, then listed signals set.
- States / outputs / next:
  - FETCH 0000: alusrcB=01, aluop=000, pcsrc=00, IRwrite=pcwrite=mem_ready; -> DECODE when mem_ready, else stay.
  - DECODE 0001: alusrcB=11, aluop=000; by op: 000000->REXEC, 100011/101011->MEMADR, 000100->BEQ, 000101->BNE, 001000->IEXEC, ANDI/ORI/SLTI->IEXEC, 000010->JUMP, other or disabled->TRAP.
  - MEMADR 0010: alusrcA=1, alusrcB=10, aluop=000; LW->MEMRD, SW->MEMWR.
  - MEMRD 0011: IorD=1; -> MEMWB on mem_ready.
  - MEMWB 0100: memtoreg=1, regwrite=1, retire=1; -> FETCH.
  - MEMWR 0101: IorD=1, memwrite=1, retire=mem_ready; -> FETCH on mem_ready.
  - REXEC 0110: alusrcA=1, alusrcB=00, aluop=010; -> ALUWB.
  - ALUWB 0111: regdst=1, regwrite=1, retire=1; -> FETCH.
  - BEQ 1000: alusrcA=1, aluop=001, pcsrc=01, branch=1, retire=1; -> FETCH.
  - BNE 1100: as BEQ but branch_ne=1, branch=0.
  - IEXEC 1001: alusrcA=1, alusrcB=10; aluop 000 ADDI, 011 ANDI, 100 ORI, 101 SLTI; -> IWB.
  - IWB 1010: regwrite=1, retire=1; -> FETCH.
  - JUMP 1011: pcsrc=10, pcwrite=1, retire=1; -> FETCH.
  - TRAP 1101: illegal=1, all enables 0; stays until reset.
- op must be stable from DECODE until retire (IR not rewritten); IEXEC/MEMADR re-read op.
- instret += 1 on each clk with retire=1, wraps at 2^CNT_W-1 -> 0.

## Timing
- Reset low at edge: state<=FETCH, instret<=0. While reset=0, pcwrite, IRwrite, memwrite, regwrite, retire forced 0; other outputs show FETCH decode; illegal=0.
- Zero-wait cycles: LW 5, SW 4, R-type 4, ADDI/ANDI/ORI/SLTI 4, BEQ/BNE 3, J 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1.
- memwrite held high through all MEMWR wait cycles; single retire on completing cycle.
- Reset mid-instruction (any state, incl. TRAP/wait): next state FETCH, no partial retire counted.
- Unused encodings 1110/1111: next state FETCH.

## Test plan
- Reset then LW, mem_ready=1: states 0,1,2,3,4,0; regwrite=memtoreg=1 only in 4; instret 0->1.
- SW, mem_ready low 3 cycles in MEMWR: memwrite=1 for 4 cycles, one retire, total 7 cycles.
- FETCH with mem_ready=0 two cycles: IRwrite=pcwrite=0 those cycles, then 1 for one cycle, DECODE next.
- BNE/ORI with enables=1: BNE gives branch_ne=1, aluop=001; ORI IEXEC aluop=100; with ENABLE_*=0 both reach TRAP, illegal=1.
- Opcode 111111: TRAP held 10 cycles, no enables, instret frozen; reset low 1 cycle -> FETCH, illegal=0.
- CNT_W=4, 16 J instructions: instret wraps 15->0; reset low during REXEC: no retire, instret 0.
